// File: rtl/wb_mem_bridge.sv
// Wishbone slave bridge to a req/ready/rvalid memory port with DRAM/VRAM/BIOS decode and timeout.
// Optional BIOS overlay of low DRAM reads is enabled by defining BIOS_OVERLAY_EN.
module wb_mem_bridge #(
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned INT_LAT     = 1,
   parameter logic [31:0] BUS_ERR_DAT = 32'hDEADBEEF
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        int_hit,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_dat,
   output logic        mem_req,
   output logic [1:0]  mem_region,
   output logic [21:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        bus_err
);

   typedef enum logic [2:0] {S_IDLE, S_INT, S_REQ, S_WAIT, S_ACK} state_t;

   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0] INT_LAST = 8'(INT_LAT - 1);

   state_t      state, state_nx;
   logic [21:0] addr_r;
   logic [31:0] wdat_r, rdat_r;
   logic [3:0]  sel_r;
   logic        we_r;
   logic [1:0]  region_r;
   logic [7:0]  cnt;
   logic        aborted;
   logic        err_r;
   logic        overlay;
   logic        dec_hit;
   logic [1:0]  dec_region;
   logic        accept, take_rd, fail;

   // Decoding the live address at accept is equivalent to decoding the latched one.
   always_comb begin
      dec_hit    = 1'b1;
      dec_region = 2'd0;
      if (overlay && !i_wb_we && (i_wb_adr < 32'h0010_0000))
         dec_region = 2'd2;
      else if (i_wb_adr < 32'h0020_0000)
         dec_region = 2'd0;
      else if (i_wb_adr < 32'h0030_0000)
         dec_region = 2'd1;
      else if (i_wb_adr[31:20] == 12'h030)
         dec_region = 2'd2;
      else
         dec_hit = 1'b0;
   end

`ifdef BIOS_OVERLAY_EN
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n)
         overlay <= 1'b1;
      else if (accept && !int_hit && dec_hit && (dec_region == 2'd0) && i_wb_we)
         overlay <= 1'b0;
   end
`else
   assign overlay = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      take_rd  = 1'b0;
      fail     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               accept = 1'b1;
               if (int_hit)
                  state_nx = S_INT;
               else if (!dec_hit) begin
                  state_nx = S_ACK;
                  fail     = 1'b1;
               end else if ((dec_region == 2'd2) && i_wb_we)
                  state_nx = S_ACK;
               else
                  state_nx = S_REQ;
            end
         end
         S_INT: if (cnt == INT_LAST) state_nx = S_ACK;
         S_REQ: begin
            if (mem_ready) begin
               if (we_r)
                  state_nx = S_ACK;
               else if (mem_rvalid) begin
                  take_rd  = 1'b1;
                  state_nx = S_ACK;
               end else
                  state_nx = S_WAIT;
            end else if (cnt == TO_LAST) begin
               fail     = 1'b1;
               state_nx = S_ACK;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               take_rd  = 1'b1;
               state_nx = S_ACK;
            end else if (cnt == TO_LAST) begin
               fail     = 1'b1;
               state_nx = S_ACK;
            end
         end
         S_ACK:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // cnt runs from the first INT/REQ cycle and keeps counting through WAIT.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         addr_r   <= '0;
         wdat_r   <= '0;
         rdat_r   <= '0;
         sel_r    <= '0;
         we_r     <= 1'b0;
         region_r <= '0;
         cnt      <= '0;
         aborted  <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= (state == S_IDLE) ? '0 : cnt + 8'd1;
         if (accept) begin
            addr_r   <= i_wb_adr[23:2];
            wdat_r   <= i_wb_dat;
            sel_r    <= i_wb_sel;
            we_r     <= i_wb_we;
            region_r <= dec_region;
         end
         if (fail)
            rdat_r <= BUS_ERR_DAT;
         else if (take_rd)
            rdat_r <= mem_rdata;
         else if (accept)
            rdat_r <= '0;
         if (fail)
            err_r <= 1'b1;
         if (state == S_IDLE)
            aborted <= 1'b0;
         else if (!i_wb_cyc)
            aborted <= 1'b1;
      end
   end

   assign o_wb_ack   = (state == S_ACK) && i_wb_cyc && !aborted;
   assign o_wb_dat   = rdat_r;
   assign mem_req    = (state == S_REQ);
   assign mem_region = region_r;
   assign mem_addr   = addr_r;
   assign mem_we     = we_r;
   assign mem_be     = sel_r;
   assign mem_wdata  = wdat_r;
   assign bus_err    = err_r;

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Scoreboard bench for wb_mem_bridge: random Wishbone traffic against a region/memory reference model.
// Overlay expectations follow BIOS_OVERLAY_EN when defined for both files.
module tb_wb_mem_bridge;
   localparam int unsigned TIMEOUT     = 255;
   localparam int unsigned INT_LAT     = 1;
   localparam logic [31:0] BUS_ERR_DAT = 32'hDEADBEEF;
`ifdef BIOS_OVERLAY_EN
   localparam bit OVL_ON = 1'b1;
`else
   localparam bit OVL_ON = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic [31:0] i_wb_adr, i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic        i_wb_we, i_wb_cyc, i_wb_stb, int_hit;
   logic        o_wb_ack;
   logic [31:0] o_wb_dat;
   logic        mem_req;
   logic [1:0]  mem_region;
   logic [21:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        bus_err;

   wb_mem_bridge #(.TIMEOUT(TIMEOUT), .INT_LAT(INT_LAT), .BUS_ERR_DAT(BUS_ERR_DAT)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n),
      .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .int_hit(int_hit),
      .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
      .mem_req(mem_req), .mem_region(mem_region), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   always #5 sys_clk = ~sys_clk;

   int unsigned cyc_no = 0;
   always @(posedge sys_clk) cyc_no <= cyc_no + 1;

   typedef struct {
      logic [31:0] dat;
      logic        chk_dat;
      logic        err;
      int unsigned lat;
      int unsigned t0;
   } ack_exp_t;

   typedef struct {
      logic [1:0]  region;
      logic [21:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_exp_t;

   ack_exp_t ack_q[$];
   req_exp_t req_q[$];

   int n_vec = 0;
   int n_bad = 0;
   int resp_mode = 0;   // 0 normal, 1 never respond, 2 ready but no read data
   int fix_rdy = -1;
   int fix_rv  = -1;

   logic [31:0] model_mem [logic [23:0]];
   logic [31:0] dev_mem   [logic [23:0]];
   logic        ovl = 1'b1;
   logic        err_exp = 1'b0;

   logic [31:0] bases [9] = '{32'h0000_0000, 32'h001F_FFE0, 32'h0020_0000, 32'h002F_FFE0,
                             32'h0300_0000, 32'h030F_FFE0, 32'h0500_0000, 32'h0030_0000,
                             32'h0310_0000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [23:0] k);
      return {k[7:0], k} ^ 32'hA5C3_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (sel[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [23:0] k);
      return model_mem.exists(k) ? model_mem[k] : init_word(k);
   endfunction

   function automatic logic [31:0] dev_rd(input logic [23:0] k);
      return dev_mem.exists(k) ? dev_mem[k] : init_word(k);
   endfunction

   // Reference behaviour of one Wishbone access, straight from the address map.
   task automatic model_xfer(input logic [31:0] a, input logic we, input logic [3:0] sel,
                             input logic [31:0] d, input logic ih,
                             output logic [31:0] dat, output logic chk, output logic down,
                             output logic [1:0] rg, output int unsigned lat);
      logic mapped;
      logic [23:0] k;
      dat = '0; chk = 1'b1; down = 1'b0; rg = 2'd0; lat = 0; mapped = 1'b1;
      if (ih) begin
         lat = INT_LAT + 1;
         return;
      end
      if (OVL_ON && ovl && !we && a < 32'h0010_0000) rg = 2'd2;
      else if (a < 32'h0020_0000) rg = 2'd0;
      else if (a < 32'h0030_0000) rg = 2'd1;
      else if (a >= 32'h0300_0000 && a < 32'h0310_0000) rg = 2'd2;
      else mapped = 1'b0;
      if (!mapped) begin
         dat = BUS_ERR_DAT; err_exp = 1'b1; lat = 1;
         return;
      end
      k = {rg, a[23:2]};
      if (we) begin
         chk = 1'b0;
         if (rg == 2'd2) begin
            lat = 1;
            return;
         end
         model_mem[k] = merge(model_rd(k), d, sel);
         down = 1'b1;
         if (rg == 2'd0) ovl = 1'b0;
      end else begin
         dat  = model_rd(k);
         down = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge sys_clk); #2;
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] sel,
                        input logic [31:0] d, input logic ih);
      i_wb_adr = a; i_wb_we = we; i_wb_sel = sel; i_wb_dat = d; int_hit = ih;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
   endtask

   task automatic release_bus();
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; int_hit = 1'b0; i_wb_we = 1'b0;
      i_wb_adr = $urandom; i_wb_dat = $urandom; i_wb_sel = 4'($urandom);
   endtask

   task automatic wait_ack(input int unsigned budget, output logic got);
      got = 1'b0;
      for (int unsigned i = 0; i < budget && !got; i++) begin
         @(posedge sys_clk); #1;
         if (o_wb_ack) got = 1'b1;
      end
      #1;
   endtask

   // abort=1 drops cyc one cycle after the strobe and expects no ack.
   task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [3:0] sel,
                          input logic [31:0] d, input logic ih, input int unsigned lat_force,
                          input logic abort);
      ack_exp_t e;
      req_exp_t r;
      logic [31:0] dat;
      logic chk, down, got;
      logic [1:0] rg;
      int unsigned lat;
      tick();
      model_xfer(a, we, sel, d, ih, dat, chk, down, rg, lat);
      if (down) begin
         r.region = rg; r.addr = a[23:2]; r.we = we; r.be = sel; r.wdata = d;
         req_q.push_back(r);
      end
      if (!abort) begin
         e.dat = dat; e.chk_dat = chk; e.err = err_exp;
         e.lat = (lat_force != 0) ? lat_force : lat; e.t0 = cyc_no;
         ack_q.push_back(e);
      end
      drive(a, we, sel, d, ih);
      if (abort) begin
         tick();
         release_bus();
         repeat (12) tick();
         check("abort_downstream_done", 32'(req_q.size()), 32'd0);
         return;
      end
      wait_ack(600, got);
      if (!got) begin
         n_vec++; n_bad++;
         $display("FAIL ack_timeout: addr %h got no ack, required one", a);
         ack_q.delete();
      end
      release_bus();
   endtask

   initial begin : responder
      req_exp_t r;
      logic [23:0] k;
      logic we_s, same;
      int dly;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge sys_clk); #1;
         mem_rdata = $urandom;
         if (mem_req && resp_mode != 1) begin
            if (req_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL unexpected_mem_req: region %0d addr %h, required none", mem_region, mem_addr);
            end else begin
               r = req_q.pop_front();
               check("mem_region", 32'(mem_region), 32'(r.region));
               check("mem_addr", 32'(mem_addr), 32'(r.addr));
               check("mem_we", 32'(mem_we), 32'(r.we));
               if (r.we) begin
                  check("mem_be", 32'(mem_be), 32'(r.be));
                  check("mem_wdata", mem_wdata, r.wdata);
               end
            end
            k = {mem_region, mem_addr};
            we_s = mem_we;
            dly = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
            repeat (dly) begin @(posedge sys_clk); #1; end
            check("mem_req_held", 32'(mem_req), 32'd1);
            mem_ready = 1'b1;
            same = 1'b0;
            if (we_s)
               dev_mem[k] = merge(dev_rd(k), mem_wdata, mem_be);
            else if (resp_mode == 0 && fix_rv < 0 && $urandom_range(0, 3) == 0) begin
               same = 1'b1; mem_rvalid = 1'b1; mem_rdata = dev_rd(k);
            end
            @(posedge sys_clk); #1;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (!we_s && !same && resp_mode == 0) begin
               dly = (fix_rv >= 0) ? fix_rv : int'($urandom_range(0, 4));
               repeat (dly) begin @(posedge sys_clk); #1; end
               mem_rvalid = 1'b1; mem_rdata = dev_rd(k);
               @(posedge sys_clk); #1;
               mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
         end
      end
   end

   initial begin : monitor
      ack_exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(posedge sys_clk); #1;
         if (prev) check("ack_one_cycle", 32'(o_wb_ack), 32'd0);
         prev = o_wb_ack;
         if (o_wb_ack) begin
            if (ack_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL spurious_ack: ack=1 required 0 (dat %h)", o_wb_dat);
            end else begin
               e = ack_q.pop_front();
               if (e.chk_dat) check("ack_dat", o_wb_dat, e.dat);
               check("bus_err", 32'(bus_err), 32'(e.err));
               if (e.lat != 0) check("ack_latency", cyc_no - e.t0, e.lat);
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: bench still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] va;
      logic [23:0] k;
      logic got;
      ack_exp_t e;
      req_exp_t r;
      reset_n = 1'b0;
      release_bus();
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_ack", 32'(o_wb_ack), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_dat", o_wb_dat, 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_region", 32'(mem_region), 32'd0);
      #1 reset_n = 1'b1;

      // Overlay sequence (plain DRAM traffic when the overlay is compiled out).
      wb_xfer(32'h0000_0004, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      wb_xfer(32'h0000_0100, 1'b1, 4'hF, 32'h1111_2222, 1'b0, 0, 1'b0);
      wb_xfer(32'h0000_0004, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);

      fix_rdy = 0;
      wb_xfer(32'h0000_1000, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 2, 1'b0);
      wb_xfer(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);

      va = 32'h0020_0010;
      k  = {2'd1, va[23:2]};
      model_mem[k] = 32'hCAFE_F00D;
      dev_mem[k]   = 32'hCAFE_F00D;
      fix_rdy = 2; fix_rv = 3;
      wb_xfer(va, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      fix_rdy = -1; fix_rv = -1;

      wb_xfer(32'h0500_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      wb_xfer(32'h0300_0040, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      wb_xfer(32'h0300_0040, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      wb_xfer(32'h0330_0000, 1'b0, 4'hF, 32'h0, 1'b1, 0, 1'b0);

      // Read that never gets mem_ready must time out.
      resp_mode = 1;
      tick();
      err_exp = 1'b1;
      e.dat = BUS_ERR_DAT; e.chk_dat = 1'b1; e.err = 1'b1; e.lat = TIMEOUT + 1; e.t0 = cyc_no;
      ack_q.push_back(e);
      drive(32'h0000_2000, 1'b0, 4'hF, 32'h0, 1'b0);
      wait_ack(TIMEOUT + 20, got);
      if (!got) begin
         n_vec++; n_bad++;
         $display("FAIL timeout_ack: no ack, required ack after %0d cycles", TIMEOUT);
         ack_q.delete();
      end
      check("timeout_mem_req_low", 32'(mem_req), 32'd0);
      release_bus();
      resp_mode = 0;

      fix_rdy = 3;
      wb_xfer(32'h0000_0200, 1'b1, 4'hF, 32'hA5A5_5A5A, 1'b0, 0, 1'b1);
      fix_rdy = -1;
      wb_xfer(32'h0000_0200, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);

      for (int n = 0; n < 150; n++)
         wb_xfer(bases[$urandom_range(0, 8)] + (32'($urandom_range(0, 7)) << 2),
                 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom,
                 ($urandom_range(0, 7) == 0), 0, 1'b0);

      // Reset while the bridge waits for read data.
      resp_mode = 2; fix_rdy = 0;
      tick();
      r.region = (OVL_ON && ovl) ? 2'd2 : 2'd0;
      va = 32'h0000_0300;
      r.addr = va[23:2]; r.we = 1'b0; r.be = 4'hF; r.wdata = '0;
      req_q.push_back(r);
      drive(va, 1'b0, 4'hF, 32'h0, 1'b0);
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      check("rst_mid_mem_req", 32'(mem_req), 32'd0);
      check("rst_mid_ack", 32'(o_wb_ack), 32'd0);
      check("rst_mid_bus_err", 32'(bus_err), 32'd0);
      err_exp = 1'b0; ovl = 1'b1;
      release_bus();
      tick(); tick();
      reset_n = 1'b1;
      resp_mode = 0; fix_rdy = -1;
      wb_xfer(va, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      wb_xfer(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 1'b0);

      repeat (5) tick();
      check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      check("req_queue_drained", 32'(req_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
